// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Digit width, FSM state encoding and minimum digit count helper.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // ceil(width * log10(2)) using a fixed-point log10(2)
    function automatic int min_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Keeps the digit decimal-correct after the following left shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    always_comb begin
        q = d;
        if (d >= DIGIT_W'(5))
            q = d + DIGIT_W'(3);
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-add-3 step per clock.
// Result is published only on completion, with a one-cycle done pulse.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic                      valid,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = DIGIT_W * DIGITS;

    state_t             state;
    logic [WIDTH-1:0]   bin_sr;
    logic [BW-1:0]      scratch;
    logic [BW-1:0]      nxt_scr;
    logic [CW-1:0]      cnt;
    logic [DIGIT_W-1:0] adj [DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (scratch[DIGIT_W*i +: DIGIT_W]),
            .q (adj[i])
        );
    end

    // Shift left across digits; each digit's top bit carries into the next
    always_comb begin
        nxt_scr = '0;
        nxt_scr[DIGIT_W-1:0] = {adj[0][DIGIT_W-2:0], bin_sr[WIDTH-1]};
        for (int i = 1; i < DIGITS; i++) begin
            nxt_scr[DIGIT_W*i +: DIGIT_W] =
                {adj[i][DIGIT_W-2:0], adj[i-1][DIGIT_W-1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            valid   <= 1'b0;
            bcd_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bin_sr  <= bin_in;
                        scratch <= '0;
                        cnt     <= CW'(WIDTH);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= nxt_scr;
                    bin_sr  <= {bin_sr[WIDTH-2:0], 1'b0};
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd_out <= nxt_scr;
                        done    <= 1'b1;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq against a decimal reference model.
// Acceptance and timing follow a cycle-level handshake model.
module tb_bin2bcd_seq;

    localparam int W  = 32;
    localparam int D  = 10;
    localparam int BW = 4 * D;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  bin_in = '0;
    logic          busy;
    logic          done;
    logic          valid;
    logic [BW-1:0] bcd_out;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [BW-1:0] exp_q[$];
    int            mcnt = 0;
    logic [BW-1:0] last_bcd = '0;
    bit            exp_valid = 1'b0;

    bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .valid   (valid),
        .bcd_out (bcd_out)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] to_bcd(input logic [W-1:0] v);
        longint unsigned x;
        logic [BW-1:0] r;
        x = longint'(v);
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Handshake model: accepted start occupies WIDTH busy cycles plus done
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mcnt = 0;
            exp_q.delete();
            last_bcd = '0;
            exp_valid = 1'b0;
        end else begin
            if (mcnt > 0) mcnt--;
            if (mcnt == 0 && start === 1'b1) begin
                exp_q.push_back(to_bcd(bin_in));
                mcnt = W + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", BW'(busy), BW'(mcnt >= 2));
            chk("done", BW'(done), BW'(mcnt == 1));
            if (mcnt == 1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard: done with no expected entry at %0t", $time);
                end else begin
                    last_bcd = exp_q.pop_front();
                    exp_valid = 1'b1;
                    chk("bcd_out", bcd_out, last_bcd);
                    for (int i = 0; i < D; i++)
                        chk("digit_le9", BW'(bcd_out[4*i +: 4] <= 4'd9), BW'(1));
                end
            end else begin
                chk("bcd_hold", bcd_out, last_bcd);
            end
            chk("valid", BW'(valid), BW'(exp_valid));
        end
    end

    task automatic wait_done(input int lim);
        int k;
        k = 0;
        while (done !== 1'b1 && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: done %b required 1 within %0d cycles", done, lim);
        end
    endtask

    task automatic run(input logic [W-1:0] v);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = $urandom;
        wait_done(W + 8);
    endtask

    initial begin
        logic [W-1:0] seq [4];
        int lim;
        seq[0] = 9; seq[1] = 10; seq[2] = 99; seq[3] = 100;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_done", BW'(done), BW'(0));
        chk("rst_valid", BW'(valid), BW'(0));
        chk("rst_bcd", bcd_out, BW'(0));
        reset = 1'b0;
        chk_en = 1'b1;

        run(32'd0);
        run(32'd12345);
        run(32'hFFFF_FFFF);

        // start pulse during busy must be ignored
        @(negedge clk);
        start = 1'b1; bin_in = 32'd999;
        @(negedge clk);
        start = 1'b0; bin_in = 32'd7;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; bin_in = 32'd12;
        wait_done(W + 8);

        // start held high, new value staged during each done cycle
        @(negedge clk);
        start = 1'b1; bin_in = seq[0];
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            wait_done(W + 8);
            bin_in = seq[i];
        end
        @(negedge clk);
        wait_done(W + 8);
        start = 1'b0;

        // reset aborts a conversion in flight
        @(negedge clk);
        start = 1'b1; bin_in = 32'd4095;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", BW'(busy), BW'(0));
        chk("abort_done", BW'(done), BW'(0));
        chk("abort_valid", BW'(valid), BW'(0));
        chk("abort_bcd", bcd_out, BW'(0));
        @(negedge clk);
        reset = 1'b0;
        run(32'd4095);

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] v;
            v = $urandom;
            if (i % 2 == 1) v = v >> $urandom_range(0, 31);
            run(v);
        end

        lim = 0;
        while ((exp_q.size() != 0 || mcnt != 0) && lim < 100) begin
            @(negedge clk);
            lim++;
        end
        if (exp_q.size() != 0 || mcnt != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries pending, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
